pc_fetch_unit: RTL and testbench
================================

// Module: pc_fetch_unit
// PURPOSE
//  Program-counter and instruction-fetch sequencer for the single-cycle core.
//  Consumes the ALU zero_flag together with the decoder branch flag and immgen
//  offset, and resolves each branch to a next PC.
//  Fetches every instruction from instruction memory over a req/ack handshake.
//  Presents each instruction to decode over a valid/ready handshake.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC loaded on reset; first fetch address.
//  ADDR_W    32             Width of PC, imem_addr and branch_offset.
// PORTS
//  clk            in   1       Core clock, rising edge.
//  rst_n          in   1       Asynchronous active-low reset.
//  imem_req       out  1       Fetch request to instruction memory.
//  imem_addr      out  ADDR_W  Fetch address; always equals pc.
//  imem_ack       in   1       Memory has returned imem_rdata for the held request.
//  imem_rdata     in   32      Instruction word; valid only in the imem_ack cycle.
//  instr          out  32      Registered instruction presented to decode.
//  instr_valid    out  1       instr is valid and not yet consumed.
//  instr_ready    in   1       Core has executed instr this cycle.
//  branch         in   1       Decoder: current instr is a conditional branch.
//  zero_flag      in   1       ALU zero result for the current instr.
//  branch_offset  in   ADDR_W  Sign-extended immgen, in halfword units.
//  pc             out  ADDR_W  Address of the instruction now in flight.
//  misalign_err   out  1       Sticky flag: branch target not word-aligned.
// BEHAVIOUR
//  Reset (async, rst_n=0)
//   - pc=RESET_PC, imem_req=0, instr=0, instr_valid=0, misalign_err=0, state=BOOT.
//   - Takes effect immediately, including mid-handshake.
//   - An outstanding request is abandoned; a late imem_ack after release is ignored.
//  FSM states: BOOT, FETCH, ISSUE, HALT.
//   - BOOT: one cycle after rst_n deasserts, then FETCH unconditionally.
//   - FETCH: imem_req=1 with imem_addr=pc, held stable until imem_ack.
//     - On the edge with imem_ack=1, capture instr<=imem_rdata and go to ISSUE.
//     - Minimum latency req->instr_valid is 1 cycle (ack in the first req cycle).
//   - ISSUE: imem_req=0, instr_valid=1; instr and pc stay stable while instr_ready=0.
//     - On the edge with instr_ready=1, sample branch, zero_flag and branch_offset.
//     - Compute next_pc; load pc<=next_pc, drop instr_valid, go to FETCH.
//   - HALT: imem_req=0, instr_valid=0, pc frozen, misalign_err=1; exits only by reset.
//  Next-PC arithmetic (ADDR_W bits, modulo 2^ADDR_W, no carry out)
//   - taken = branch & zero_flag.
//   - Taken: target = pc + (branch_offset << 1).
//   - Not taken: target = pc + 4; 32'hFFFF_FFFC wraps to 32'h0000_0000.
//   - Negative offsets wrap the same way, e.g. pc=0, offset=-2 gives 32'hFFFF_FFFC.
//   - If taken and target[1:0]!=0: pc is not updated, set misalign_err, go to HALT.
//  Handshake rules
//   - imem_ack is ignored outside FETCH.
//   - instr_ready is ignored when instr_valid=0.
//   - branch and zero_flag are don't-care except on the consuming edge.
//   - At most one outstanding request; pipelining and prefetch are not supported.
//   - Throughput: one instruction per 2 cycles minimum (FETCH, ISSUE).
// TESTING
//  1. Reset, then ack on the first req cycle:
//     - imem_addr=0 in cycle 2, instr_valid in cycle 3.
//     - With instr_ready=1: pc=4, second req at addr 4.
//  2. Memory ack delayed 5 cycles:
//     - imem_req and imem_addr stay stable all 5 cycles.
//     - instr equals imem_rdata from the ack cycle (32'h0000_0013).
//  3. pc=0x100, branch=1, zero_flag=1, offset=-8 -> next fetch at 0xF0.
//     - Same inputs with zero_flag=0 -> next fetch at 0x104.
//  4. pc=32'hFFFF_FFFC, not taken -> pc wraps to 0, next imem_addr=0.
//  5. Taken branch with offset=1 (target pc+2):
//     - misalign_err=1, HALT, no further imem_req.
//     - instr_valid=0 until rst_n pulses low.
//  6. rst_n low mid-FETCH, then ack while in reset:
//     - All outputs return to reset values; the ack is ignored.
//     - After release, refetch starts from RESET_PC.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: PC sequencer fetching over req/ack and issuing to decode over valid/ready.
module pc_fetch_unit #(
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       instr,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              branch,
  input  logic              zero_flag,
  input  logic [ADDR_W-1:0] branch_offset,
  output logic [ADDR_W-1:0] pc,
  output logic              misalign_err
);
  typedef enum logic [1:0] {BOOT, FETCH, ISSUE, HALT} state_t;
  state_t r_state, w_next;
  logic [ADDR_W-1:0] r_pc, w_target;
  logic [31:0] r_instr;
  logic r_misalign, w_taken, w_misalign, w_consume;
  assign w_taken = branch & zero_flag;
  assign w_target = w_taken ? r_pc + {branch_offset[ADDR_W-2:0], 1'b0} : r_pc + ADDR_W'(4);
  assign w_misalign = w_taken & |w_target[1:0];
  assign w_consume = (r_state == ISSUE) & instr_ready;
  assign pc = r_pc;
  assign imem_addr = r_pc;
  assign instr = r_instr;
  assign misalign_err = r_misalign;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= BOOT;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      BOOT:  w_next = FETCH;
      FETCH: w_next = imem_ack ? ISSUE : FETCH;
      ISSUE: w_next = !instr_ready ? ISSUE : w_misalign ? HALT : FETCH;
      HALT:  w_next = HALT;
      default: w_next = BOOT;
    endcase
  end
  always_comb begin
    imem_req = r_state == FETCH;
    instr_valid = r_state == ISSUE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_pc <= RESET_PC;
      r_instr <= '0;
      r_misalign <= 1'b0;
    end else begin
      if (r_state == FETCH && imem_ack) r_instr <= imem_rdata;
      if (w_consume && !w_misalign) r_pc <= w_target;
      if (w_consume && w_misalign) r_misalign <= 1'b1;
    end
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed-vector bench for pc_fetch_unit.
module tb_pc_fetch_unit;
  logic clk = 1'b0, rst_n = 1'b0;
  logic imem_req, imem_ack = 1'b0, instr_valid, instr_ready = 1'b0;
  logic branch = 1'b0, zero_flag = 1'b0, misalign_err;
  logic [31:0] imem_addr, imem_rdata = '0, instr, branch_offset = '0, pc;
  int checks = 0, errors = 0;
  pc_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .branch(branch),
    .zero_flag(zero_flag), .branch_offset(branch_offset), .pc(pc),
    .misalign_err(misalign_err)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, got, exp);
    end
  endtask
  task automatic chk_out(input string tag, input logic req, input logic [31:0] p,
                         input logic vld, input logic mis);
    chk({tag, "_req"}, 32'(imem_req), 32'(req));
    chk({tag, "_pc"}, pc, p);
    chk({tag, "_addr"}, imem_addr, p);
    chk({tag, "_valid"}, 32'(instr_valid), 32'(vld));
    chk({tag, "_mis"}, 32'(misalign_err), 32'(mis));
  endtask
  task automatic fetch_issue(input logic [31:0] word);
    imem_ack = 1'b1;
    imem_rdata = word;
    step();
    imem_ack = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    chk("issue_instr", instr, word);
  endtask
  task automatic consume(input logic b, input logic z, input logic [31:0] off);
    instr_ready = 1'b1;
    branch = b;
    zero_flag = z;
    branch_offset = off;
    step();
    instr_ready = 1'b0;
    branch = 1'b0;
    zero_flag = 1'b0;
    branch_offset = 32'h5555_5555;
  endtask
  initial begin
    #1;
    chk_out("rst", 1'b0, 32'h0, 1'b0, 1'b0);
    chk("rst_instr", instr, 32'h0);
    step();
    rst_n = 1'b1;
    chk_out("boot", 1'b0, 32'h0, 1'b0, 1'b0);
    step();
    chk_out("t1_fetch", 1'b1, 32'h0, 1'b0, 1'b0);
    fetch_issue(32'h0050_0093);
    chk_out("t1_issue", 1'b0, 32'h0, 1'b1, 1'b0);
    consume(1'b0, 1'b0, 32'h0);
    chk_out("t1_next", 1'b1, 32'h4, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      imem_rdata = 32'hBAD0_0000 + 32'(i);
      step();
      chk_out("t2_wait", 1'b1, 32'h4, 1'b0, 1'b0);
    end
    chk("t2_instr_hold", instr, 32'h0050_0093);
    fetch_issue(32'h0000_0013);
    for (int i = 0; i < 2; i++) begin
      step();
      chk_out("t2_stall", 1'b0, 32'h4, 1'b1, 1'b0);
      chk("t2_stall_instr", instr, 32'h0000_0013);
    end
    consume(1'b1, 1'b1, 32'h0000_007E);
    chk_out("t3_to100", 1'b1, 32'h100, 1'b0, 1'b0);
    fetch_issue(32'h1111_1111);
    consume(1'b1, 1'b1, 32'hFFFF_FFF8);
    chk_out("t3_taken", 1'b1, 32'hF0, 1'b0, 1'b0);
    fetch_issue(32'h2222_2222);
    consume(1'b1, 1'b1, 32'h0000_0008);
    chk_out("t3_back", 1'b1, 32'h100, 1'b0, 1'b0);
    fetch_issue(32'h3333_3333);
    consume(1'b1, 1'b0, 32'hFFFF_FFF8);
    chk_out("t3_nottaken", 1'b1, 32'h104, 1'b0, 1'b0);
    fetch_issue(32'h4444_4444);
    consume(1'b1, 1'b1, 32'hFFFF_FF7C);
    chk_out("t4_top", 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
    fetch_issue(32'h5555_0000);
    consume(1'b0, 1'b1, 32'h0000_0010);
    chk_out("t4_wrap", 1'b1, 32'h0, 1'b0, 1'b0);
    fetch_issue(32'h6666_6666);
    consume(1'b1, 1'b1, 32'hFFFF_FFFE);
    chk_out("t4_negwrap", 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
    fetch_issue(32'h7777_7777);
    consume(1'b1, 1'b0, 32'h0);
    chk_out("t4_wrap2", 1'b1, 32'h0, 1'b0, 1'b0);
    fetch_issue(32'h8888_8888);
    consume(1'b1, 1'b1, 32'h0000_0001);
    chk_out("t5_halt", 1'b0, 32'h0, 1'b0, 1'b1);
    imem_ack = 1'b1;
    instr_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk_out("t5_stay", 1'b0, 32'h0, 1'b0, 1'b1);
    end
    imem_ack = 1'b0;
    instr_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_out("t5_rst", 1'b0, 32'h0, 1'b0, 1'b0);
    step();
    rst_n = 1'b1;
    step();
    chk_out("t6_fetch", 1'b1, 32'h0, 1'b0, 1'b0);
    imem_rdata = 32'hCAFE_F00D;
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("t6_async", 1'b0, 32'h0, 1'b0, 1'b0);
    chk("t6_instr", instr, 32'h0);
    imem_ack = 1'b1;
    step();
    chk_out("t6_inrst", 1'b0, 32'h0, 1'b0, 1'b0);
    chk("t6_instr2", instr, 32'h0);
    rst_n = 1'b1;
    step();
    chk_out("t6_late", 1'b1, 32'h0, 1'b0, 1'b0);
    chk("t6_ignored", instr, 32'h0);
    imem_ack = 1'b0;
    step();
    chk_out("t6_refetch", 1'b1, 32'h0, 1'b0, 1'b0);
    fetch_issue(32'h0000_0013);
    chk_out("t6_issue", 1'b0, 32'h0, 1'b1, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
